// File: rtl/fpu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_cmd_sequencer
//
// Command sequencer for the half-precision FPU datapath. Host ADD/SUB/MULT
// commands are queued in a small circular FIFO and issued one at a time to
// the asynchronous adder or multiplier over a 4-phase req/ack handshake.
// Results come back in command order through a single-entry response
// register. A sticky interrupt is raised each time that register is loaded.
//
// Ports
//   clk, rst_n              clock and asynchronous active-low reset
//   cmd_valid/cmd_ready     host command handshake (push on valid && ready)
//   cmd_op, cmd_a, cmd_b    opcode (000 ADD, 001 SUB, 010 MULT) and FP16 operands
//   fpu_a, fpu_b            operands driven to both arithmetic units
//   add_req/add_ack         adder 4-phase handshake (ack is asynchronous)
//   mul_req/mul_ack         multiplier 4-phase handshake (ack is asynchronous)
//   add_result, mul_result  unit results, valid while the matching ack is high
//   rsp_valid/rsp_ready     response handshake (consume on valid && ready)
//   rsp_data, rsp_err       result; 7E00/err on timeout, 0000/err on illegal op
//   busy                    sequencer active or commands waiting
//   irq, irq_clr            sticky response interrupt and its clear
//   q_count                 commands waiting in the queue (in-flight excluded)
// ---------------------------------------------------------------------------
module fpu_cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [15:0]            cmd_a,
    input  logic [15:0]            cmd_b,
    output logic [15:0]            fpu_a,
    output logic [15:0]            fpu_b,
    output logic                   add_req,
    output logic                   mul_req,
    input  logic                   add_ack,
    input  logic                   mul_ack,
    input  logic [15:0]            add_result,
    input  logic [15:0]            mul_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   irq,
    input  logic                   irq_clr,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0]      OP_ADD   = 3'b000;
    localparam logic [2:0]      OP_SUB   = 3'b001;
    localparam logic [2:0]      OP_MUL   = 3'b010;
    localparam logic [15:0]     QNAN     = 16'h7E00;
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);
    localparam logic [CW-1:0]   TMO_LAST = CW'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    // -----------------------------------------------------------------------
    // Ack synchronisers, one chain per unit (index 0 adder, 1 multiplier).
    // The chains reset to all-ones so that after a reset the IDLE guard
    // treats the ack as still high until the unit is actually seen low for
    // SYNC_STAGES cycles; a unit that was mid-handshake when reset hit can
    // never be mistaken for an idle one.
    // -----------------------------------------------------------------------
    logic [1:0] ack_in;
    logic [1:0] ack_sync;

    assign ack_in = {mul_ack, add_ack};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack_sync
            logic [SYNC_STAGES-1:0] sync_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '1;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], ack_in[gi]};
                end
            end

            assign ack_sync[gi] = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Command queue storage: {op, a, b} per entry. The head is only ever
    // consumed through the cur_* registers, so the read is registered.
    // -----------------------------------------------------------------------
    logic [34:0] q_mem [DEPTH];

    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNTW-1:0] count_reg,  count_next;
    logic            q_empty;
    logic            push;
    logic            pop;

    assign q_empty   = (count_reg == '0);
    assign cmd_ready = (count_reg != CNT_FULL);
    assign push      = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_reg] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer state and datapath registers
    // -----------------------------------------------------------------------
    state_t        state_reg,     state_next;
    logic [2:0]    cur_op_reg,    cur_op_next;
    logic [15:0]   cur_a_reg,     cur_a_next;
    logic [15:0]   cur_b_reg,     cur_b_next;
    logic [15:0]   fpu_a_reg,     fpu_a_next;
    logic [15:0]   fpu_b_reg,     fpu_b_next;
    logic          add_req_reg,   add_req_next;
    logic          mul_req_reg,   mul_req_next;
    logic [CW-1:0] tmo_reg,       tmo_next;
    logic [15:0]   res_data_reg,  res_data_next;
    logic          res_err_reg,   res_err_next;
    logic          rsp_valid_reg, rsp_valid_next;
    logic [15:0]   rsp_data_reg,  rsp_data_next;
    logic          rsp_err_reg,   rsp_err_next;
    logic          irq_reg,       irq_next;

    logic cur_is_mul;
    logic cur_legal;
    logic sel_ack;

    assign cur_is_mul = (cur_op_reg == OP_MUL);
    assign cur_legal  = (cur_op_reg == OP_ADD) || (cur_op_reg == OP_SUB) ||
                        (cur_op_reg == OP_MUL);
    // Only the ack of the unit that owns the current command matters once
    // issued; the other unit is idle.
    assign sel_ack    = cur_is_mul ? ack_sync[1] : ack_sync[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            cur_op_reg    <= '0;
            cur_a_reg     <= '0;
            cur_b_reg     <= '0;
            fpu_a_reg     <= '0;
            fpu_b_reg     <= '0;
            add_req_reg   <= 1'b0;
            mul_req_reg   <= 1'b0;
            tmo_reg       <= '0;
            res_data_reg  <= '0;
            res_err_reg   <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            cur_op_reg    <= cur_op_next;
            cur_a_reg     <= cur_a_next;
            cur_b_reg     <= cur_b_next;
            fpu_a_reg     <= fpu_a_next;
            fpu_b_reg     <= fpu_b_next;
            add_req_reg   <= add_req_next;
            mul_req_reg   <= mul_req_next;
            tmo_reg       <= tmo_next;
            res_data_reg  <= res_data_next;
            res_err_reg   <= res_err_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
            irq_reg       <= irq_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        cur_op_next    = cur_op_reg;
        cur_a_next     = cur_a_reg;
        cur_b_next     = cur_b_reg;
        fpu_a_next     = fpu_a_reg;
        fpu_b_next     = fpu_b_reg;
        add_req_next   = add_req_reg;
        mul_req_next   = mul_req_reg;
        tmo_next       = tmo_reg;
        res_data_next  = res_data_reg;
        res_err_next   = res_err_reg;
        // A consumed response clears unless DONE reloads it below.
        rsp_valid_next = rsp_valid_reg && !rsp_ready;
        rsp_data_next  = rsp_data_reg;
        rsp_err_next   = rsp_err_reg;
        // A load in DONE overrides a clear in the same cycle.
        irq_next       = irq_reg && !irq_clr;
        pop            = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // Both units must be back at ack-low before a new handshake.
                if (!q_empty && !ack_sync[0] && !ack_sync[1]) begin
                    pop = 1'b1;
                    {cur_op_next, cur_a_next, cur_b_next} = q_mem[rd_ptr_reg];
                    state_next = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (cur_legal) begin
                    fpu_a_next   = cur_a_reg;
                    // SUB reuses the adder with the sign of B inverted.
                    fpu_b_next   = (cur_op_reg == OP_SUB) ?
                                   {~cur_b_reg[15], cur_b_reg[14:0]} : cur_b_reg;
                    add_req_next = !cur_is_mul;
                    mul_req_next = cur_is_mul;
                    tmo_next     = '0;
                    state_next   = S_WAIT_HI;
                end else begin
                    res_data_next = 16'h0000;
                    res_err_next  = 1'b1;
                    state_next    = S_DONE;
                end
            end

            S_WAIT_HI: begin
                if (sel_ack) begin
                    res_data_next = cur_is_mul ? mul_result : add_result;
                    res_err_next  = 1'b0;
                    add_req_next  = 1'b0;
                    mul_req_next  = 1'b0;
                    state_next    = S_WAIT_LO;
                end else if (tmo_reg + CW'(1) == TMO_LAST) begin
                    // req falls exactly ACK_TIMEOUT cycles after it rose.
                    res_data_next = QNAN;
                    res_err_next  = 1'b1;
                    add_req_next  = 1'b0;
                    mul_req_next  = 1'b0;
                    state_next    = S_WAIT_LO;
                end else begin
                    tmo_next = tmo_reg + CW'(1);
                end
            end

            S_WAIT_LO: begin
                if (!sel_ack) begin
                    state_next = S_DONE;
                end
            end

            S_DONE: begin
                if (!rsp_valid_reg || rsp_ready) begin
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = res_data_reg;
                    rsp_err_next   = res_err_reg;
                    irq_next       = 1'b1;
                    state_next     = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNTW'(1);
            2'b01:   count_next = count_reg - CNTW'(1);
            default: count_next = count_reg;
        endcase
    end

    assign fpu_a     = fpu_a_reg;
    assign fpu_b     = fpu_b_reg;
    assign add_req   = add_req_reg;
    assign mul_req   = mul_req_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign irq       = irq_reg;
    assign busy      = (state_reg != S_IDLE) || !q_empty;
    assign q_count   = count_reg;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
`timescale 1ns/1ps
// Testbench for fpu_cmd_sequencer: behavioural ack models for both units,
// an in-order queue of expected responses, and directed plus random steps.
module tb_fpu_cmd_sequencer;

    localparam int DEPTH       = 4;
    localparam int ACK_TIMEOUT = 255;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [15:0] fpu_a;
    logic [15:0] fpu_b;
    logic        add_req;
    logic        mul_req;
    logic        add_ack = 1'b0;
    logic        mul_ack = 1'b0;
    logic [15:0] add_result = 16'h0000;
    logic [15:0] mul_result = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        irq;
    logic        irq_clr;
    logic [$clog2(DEPTH):0] q_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fpu_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .add_req    (add_req),
        .mul_req    (mul_req),
        .add_ack    (add_ack),
        .mul_ack    (mul_ack),
        .add_result (add_result),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .irq        (irq),
        .irq_clr    (irq_clr),
        .q_count    (q_count)
    );

    // ---------------- comparison helpers ----------------
    task automatic check1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- arithmetic unit stand-ins ----------------
    // Real FP16 results for the directed operand pairs, an arbitrary but
    // deterministic mix for everything else.
    function automatic logic [15:0] unit_add(input logic [15:0] x, input logic [15:0] y);
        if (x == 16'h3C00 && y == 16'h4000) return 16'h4200;   // 1 + 2 = 3
        if (x == 16'h4200 && y == 16'hBC00) return 16'h4000;   // 3 + -1 = 2
        return x + y;
    endfunction

    function automatic logic [15:0] unit_mul(input logic [15:0] x, input logic [15:0] y);
        if (x == 16'h4000 && y == 16'h4200) return 16'h4600;   // 2 * 3 = 6
        return x ^ {y[7:0], y[15:8]};
    endfunction

    // Expected response for a host command: {err, data}.
    function automatic logic [16:0] model_rsp(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input bit silent);
        if (op > 3'd2) return {1'b1, 16'h0000};
        if (op != 3'd2 && silent) return {1'b1, 16'h7E00};
        case (op)
            3'd0:    return {1'b0, unit_add(a, b)};
            3'd1:    return {1'b0, unit_add(a, b ^ 16'h8000)};
            default: return {1'b0, unit_mul(a, b)};
        endcase
    endfunction

    // ---------------- ack models ----------------
    int add_dly = 3;
    int mul_dly = 3;
    int add_cnt = 0;
    int mul_cnt = 0;
    bit add_silent = 1'b0;
    bit add_hold   = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (add_hold) begin
            add_ack = 1'b1;
        end else if (add_req && !add_ack && !add_silent) begin
            add_cnt++;
            if (add_cnt >= add_dly) begin
                add_ack    = 1'b1;
                add_result = unit_add(fpu_a, fpu_b);
                add_cnt    = 0;
            end
        end else if (!add_req && add_ack) begin
            add_cnt++;
            if (add_cnt >= add_dly) begin
                add_ack    = 1'b0;
                add_result = 16'hDEAD;
                add_cnt    = 0;
            end
        end else begin
            add_cnt = 0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (mul_req && !mul_ack) begin
            mul_cnt++;
            if (mul_cnt >= mul_dly) begin
                mul_ack    = 1'b1;
                mul_result = unit_mul(fpu_a, fpu_b);
                mul_cnt    = 0;
            end
        end else if (!mul_req && mul_ack) begin
            mul_cnt++;
            if (mul_cnt >= mul_dly) begin
                mul_ack    = 1'b0;
                mul_result = 16'hDEAD;
                mul_cnt    = 0;
            end
        end else begin
            mul_cnt = 0;
        end
    end

    // ---------------- req pulse counter and operand stability ----------------
    int          add_pulses = 0;
    int          mul_pulses = 0;
    logic        prev_add   = 1'b0;
    logic        prev_mul   = 1'b0;
    logic [15:0] hold_a     = 16'h0000;
    logic [15:0] hold_b     = 16'h0000;

    always @(negedge clk) begin
        if (add_req && !prev_add) add_pulses++;
        if (mul_req && !prev_mul) mul_pulses++;
        if ((add_req && prev_add) || (mul_req && prev_mul)) begin
            check16("operand_a_stable", fpu_a, hold_a);
            check16("operand_b_stable", fpu_b, hold_b);
        end
        hold_a   = fpu_a;
        hold_b   = fpu_b;
        prev_add = add_req;
        prev_mul = mul_req;
    end

    // ---------------- expected-response queue and host tasks ----------------
    logic [16:0] exp_q[$];

    task automatic push(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check1("push_ready", cmd_ready, 1'b1);
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        exp_q.push_back(model_rsp(op, a, b, add_silent));
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("[TB] push op=%0d a=%h b=%h", op, a, b);
    endtask

    task automatic get_rsp(input string tag);
        int n = 0;
        logic [16:0] e;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check1({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        if (!rsp_valid) return;
        checkn({tag, "_expected_pending"}, int'(exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check16({tag, "_data"}, rsp_data, e[15:0]);
        check1({tag, "_err"}, rsp_err, e[16]);
        check1({tag, "_irq"}, irq, 1'b1);
        $display("[TB] rsp %s data=%h err=%b (expected %h/%b)", tag, rsp_data, rsp_err, e[15:0], e[16]);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic wait_add_req(input string tag);
        int n = 0;
        while (!add_req && n < 500) begin
            @(negedge clk);
            n++;
        end
        check1({tag, "_add_req_rise"}, add_req, 1'b1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(400_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random steps ----------------
    initial begin
        int p_add, p_mul, n, accepted;
        logic [2:0] rop;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 16'h0000;
        cmd_b     = 16'h0000;
        rsp_ready = 1'b0;
        irq_clr   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check1("rst_cmd_ready", cmd_ready, 1'b1);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check1("rst_irq", irq, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_add_req", add_req, 1'b0);
        check1("rst_mul_req", mul_req, 1'b0);
        check16("rst_rsp_data", rsp_data, 16'h0000);
        check16("rst_fpu_a", fpu_a, 16'h0000);
        checkn("rst_q_count", int'(q_count), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // ADD with first-word latency
        p_add = add_pulses;
        p_mul = mul_pulses;
        push(3'd0, 16'h3C00, 16'h4000);
        check1("lat_edge_n", add_req, 1'b0);
        @(negedge clk);
        check1("lat_edge_n1", add_req, 1'b0);
        @(negedge clk);
        check1("lat_edge_n2", add_req, 1'b1);
        check1("add_no_mul_req", mul_req, 1'b0);
        check1("add_busy", busy, 1'b1);
        get_rsp("add");
        checkn("add_pulse_count", add_pulses - p_add, 1);
        checkn("add_mul_pulse_count", mul_pulses - p_mul, 0);

        // irq clear
        check1("irq_sticky", irq, 1'b1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check1("irq_cleared", irq, 1'b0);

        // SUB: adder sees negated B
        push(3'd1, 16'h4200, 16'h3C00);
        wait_add_req("sub");
        check16("sub_fpu_a", fpu_a, 16'h4200);
        check16("sub_fpu_b", fpu_b, 16'hBC00);
        get_rsp("sub");

        // MULT: multiplier only
        p_add = add_pulses;
        p_mul = mul_pulses;
        push(3'd2, 16'h4000, 16'h4200);
        get_rsp("mul");
        checkn("mul_pulse_count", mul_pulses - p_mul, 1);
        checkn("mul_add_pulse_count", add_pulses - p_add, 0);

        // Illegal op followed by ADD; irq_clr held across the load
        p_add = add_pulses;
        p_mul = mul_pulses;
        irq_clr = 1'b1;
        push(3'b101, 16'h1234, 16'h5678);
        push(3'd0, 16'h3C00, 16'h4000);
        n = 0;
        while (!rsp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check1("irq_set_beats_clr", irq, 1'b1);
        irq_clr = 1'b0;
        get_rsp("illegal");
        get_rsp("after_illegal");
        checkn("illegal_add_pulses", add_pulses - p_add, 1);
        checkn("illegal_mul_pulses", mul_pulses - p_mul, 0);

        // Silent adder: timeout after exactly ACK_TIMEOUT cycles
        add_silent = 1'b1;
        push(3'd0, 16'h3C00, 16'h4000);
        wait_add_req("timeout");
        n = 0;
        while (add_req && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkn("timeout_req_width", n, ACK_TIMEOUT);
        add_silent = 1'b0;
        get_rsp("timeout");

        // Fill with response held: DEPTH+2 accepted
        accepted = 0;
        for (int c = 0; c < 200; c++) begin
            cmd_valid = cmd_ready;
            if (cmd_ready) begin
                rop    = 3'($urandom_range(0, 5));
                cmd_op = rop;
                cmd_a  = 16'($urandom_range(0, 65535));
                cmd_b  = 16'($urandom_range(0, 65535));
                exp_q.push_back(model_rsp(rop, cmd_a, cmd_b, 1'b0));
                accepted++;
                $display("[TB] fill push op=%0d a=%h b=%h", rop, cmd_a, cmd_b);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checkn("fill_accepted", accepted, DEPTH + 2);
        checkn("fill_q_count", int'(q_count), DEPTH);
        check1("fill_cmd_ready", cmd_ready, 1'b0);
        check1("fill_busy", busy, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) get_rsp("fill_drain");
        checkn("drain_q_count", int'(q_count), 0);

        // Random commands with random unit latency and consumption
        for (int i = 0; i < 40; i++) begin
            add_dly = $urandom_range(1, 5);
            mul_dly = $urandom_range(1, 5);
            if ($urandom_range(0, 4) == 0) rop = 3'($urandom_range(3, 7));
            else                           rop = 3'($urandom_range(0, 2));
            push(rop, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            if (exp_q.size() >= 3 || $urandom_range(0, 1) == 1) get_rsp("rand");
        end
        while (exp_q.size() > 0) get_rsp("rand_drain");
        checkn("rand_q_count", int'(q_count), 0);

        // Reset during WAIT_HI with the adder ack held high
        add_dly = 3;
        push(3'd0, 16'h3C00, 16'h4000);
        n = 0;
        while (!rsp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check1("prereset_rsp_valid", rsp_valid, 1'b1);
        add_dly = 100;
        push(3'd0, 16'h4200, 16'hBC00);
        wait_add_req("prereset");
        add_hold = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check1("midrst_add_req", add_req, 1'b0);
        check1("midrst_rsp_valid", rsp_valid, 1'b0);
        check1("midrst_irq", irq, 1'b0);
        check1("midrst_cmd_ready", cmd_ready, 1'b1);
        checkn("midrst_q_count", int'(q_count), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        add_dly = 2;
        p_add   = add_pulses;
        push(3'd0, 16'h3C00, 16'h4000);
        repeat (20) @(negedge clk);
        checkn("guard_no_reissue", add_pulses - p_add, 0);
        check1("guard_add_req_low", add_req, 1'b0);
        add_hold = 1'b0;
        get_rsp("post_reset");
        checkn("post_reset_pulses", add_pulses - p_add, 1);
        check1("end_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
